// File: rtl/tl_arb_pkg.sv
// Shared widths, field offsets, opcodes and helpers for the two-client TL-UH arbiter.
package tl_arb_pkg;

  localparam int N_CLIENTS    = 2;
  localparam int MAX_INFLIGHT = 8;
  localparam int BEAT_BYTES   = 4;

  // Packed A beat: {opcode[2:0], param[2:0], size[2:0], source[5:0], address[24:0], mask[3:0], data[31:0]}
  localparam int A_W         = 76;
  localparam int A_SRC_LSB   = 61;
  localparam int A_SIZE_LSB  = 67;
  localparam int A_OP_LSB    = 73;

  // Packed D beat: {opcode[2:0], param[1:0], size[2:0], source[6:0], sink, denied, corrupt, data[31:0]}
  localparam int D_W         = 50;
  localparam int D_SRC_LSB   = 35;
  localparam int D_SIZE_LSB  = 42;
  localparam int D_OP_LSB    = 47;

  // A channel opcodes
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGIC       = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] HINT        = 3'd5;

  // D channel opcodes
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;

  typedef enum logic {
    A_IDLE,
    A_BURST
  } a_state_e;

  // Number of data beats a message of the given size occupies (never less than one).
  function automatic logic [7:0] beats(input logic [2:0] size);
    logic [7:0] n;
    n = (8'd1 << size) / 8'(BEAT_BYTES);
    return (n == 8'd0) ? 8'd1 : n;
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Tracks the beats of one multi-beat message; flags the first and last beat of each message.
module tl_beat_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       fire,
  input  logic [7:0] load_beats,
  output logic       first,
  output logic       last
);

  logic [7:0] remaining_q;
  logic [7:0] remaining_d;

  // A zero remainder means the next beat to fire opens a new message.
  assign first = (remaining_q == 8'd0);
  assign last  = first ? (load_beats <= 8'd1) : (remaining_q == 8'd1);

  // Load the beats still owed after the first one, then count them down.
  always_comb begin
    remaining_d = remaining_q;
    if (load) begin
      remaining_d = (load_beats > 8'd1) ? load_beats - 8'd1 : 8'd0;
    end else if (fire && !first) begin
      remaining_d = remaining_q - 8'd1;
    end
  end

  // Remainder register, cleared on reset so a partial message is abandoned.
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining_q <= 8'd0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: rtl/tl_a_client_arbiter.sv
// Two-client TL-UH arbiter: round-robin A with burst lock, D routed back by source tag.
module tl_a_client_arbiter
  import tl_arb_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             in_a_valid,
  output logic [1:0]             in_a_ready,
  input  logic [2*A_W-1:0]       in_a_bits,
  output logic                   out_a_valid,
  input  logic                   out_a_ready,
  output logic [A_W:0]           out_a_bits,
  input  logic                   out_d_valid,
  output logic                   out_d_ready,
  input  logic [D_W-1:0]         out_d_bits,
  output logic [1:0]             in_d_valid,
  input  logic [1:0]             in_d_ready,
  output logic [2*(D_W-1)-1:0]   in_d_bits,
  output logic [3:0]             inflight
);

  a_state_e   state_q, state_d;
  logic       rr_q, rr_d;
  logic       lock_q, lock_d;
  logic [3:0] inflight_q, inflight_d;

  logic           winner;
  logic           sel;
  logic           full;
  logic [A_W-1:0] sel_bits;
  logic [2:0]     sel_op;
  logic [2:0]     sel_size;
  logic [7:0]     a_load_beats;
  logic           a_fire;
  logic           a_first;
  logic           a_last;

  logic           tgt;
  logic [2:0]     d_op;
  logic [2:0]     d_size;
  logic [7:0]     d_load_beats;
  logic [D_W-2:0] d_stripped;
  logic           d_fire;
  logic           d_first;
  logic           d_last;

  assign full = (inflight_q == 4'(MAX_INFLIGHT));

  // Round-robin pick: the pointed-to client wins unless it is idle and the other is not.
  always_comb begin
    winner = (in_a_valid[rr_q] || !in_a_valid[~rr_q]) ? rr_q : ~rr_q;
  end

  assign sel      = (state_q == A_BURST) ? lock_q : winner;
  assign sel_bits = sel ? in_a_bits[2*A_W-1:A_W] : in_a_bits[A_W-1:0];
  assign sel_op   = sel_bits[A_OP_LSB +: 3];
  assign sel_size = sel_bits[A_SIZE_LSB +: 3];

  assign a_load_beats = (sel_op == PUT_FULL || sel_op == PUT_PARTIAL) ? beats(sel_size) : 8'd1;

  // Downstream source carries the client index above the client's own 6-bit source.
  assign out_a_bits = {sel_bits[A_W-1:A_SRC_LSB+6], sel, sel_bits[A_SRC_LSB+5:0]};

  // FSM outputs: in a burst only the locked client passes and the inflight limit is ignored.
  always_comb begin
    out_a_valid = 1'b0;
    in_a_ready  = 2'b00;
    if (!reset) begin
      if (state_q == A_BURST) begin
        out_a_valid        = in_a_valid[lock_q];
        in_a_ready[lock_q] = out_a_ready;
      end else begin
        out_a_valid        = in_a_valid[winner] & ~full;
        in_a_ready[winner] = out_a_ready & ~full;
      end
    end
  end

  assign a_fire = out_a_valid & out_a_ready;

  // FSM next state: a multi-beat Put first beat locks the winner until its last beat.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    case (state_q)
      A_IDLE: begin
        if (a_fire) begin
          rr_d   = ~winner;
          lock_d = winner;
          if (!a_last) begin
            state_d = A_BURST;
          end
        end
      end
      A_BURST: begin
        if (a_fire && a_last) begin
          state_d = A_IDLE;
        end
      end
      default: state_d = A_IDLE;
    endcase
  end

  tl_beat_counter u_a_beats (
    .clock      (clock),
    .reset      (reset),
    .load       (a_fire && (state_q == A_IDLE)),
    .fire       (a_fire),
    .load_beats (a_load_beats),
    .first      (a_first),
    .last       (a_last)
  );

  // D routing: the top source bit selects the client; that bit is dropped on the way up.
  assign tgt        = out_d_bits[D_SRC_LSB+6];
  assign d_op       = out_d_bits[D_OP_LSB +: 3];
  assign d_size     = out_d_bits[D_SIZE_LSB +: 3];
  assign d_stripped = {out_d_bits[D_W-1:D_SRC_LSB+7], out_d_bits[D_SRC_LSB+5:0]};
  assign in_d_bits  = {d_stripped, d_stripped};
  assign d_load_beats = (d_op == ACK_DATA) ? beats(d_size) : 8'd1;

  // Steer D valid to the tagged client and take its ready back.
  always_comb begin
    in_d_valid  = 2'b00;
    out_d_ready = 1'b0;
    if (!reset) begin
      in_d_valid[tgt] = out_d_valid;
      out_d_ready     = in_d_ready[tgt];
    end
  end

  assign d_fire = out_d_valid & out_d_ready;

  tl_beat_counter u_d_beats (
    .clock      (clock),
    .reset      (reset),
    .load       (d_fire && d_first),
    .fire       (d_fire),
    .load_beats (d_load_beats),
    .first      (d_first),
    .last       (d_last)
  );

  // Outstanding count: up on an accepted first A beat, down on a last D beat, saturating at 0.
  always_comb begin
    inflight_d = inflight_q;
    if ((a_fire && a_first) && !(d_fire && d_last)) begin
      inflight_d = inflight_q + 4'd1;
    end else if ((d_fire && d_last) && !(a_fire && a_first) && (inflight_q != 4'd0)) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  assign inflight = inflight_q;

  // State register for the A FSM, round-robin pointer, lock owner and outstanding count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= A_IDLE;
      rr_q       <= 1'b0;
      lock_q     <= 1'b0;
      inflight_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_tl_a_client_arbiter.sv
// Self-checking bench for tl_a_client_arbiter: vector table, directed corner sequences, random run.
module tb_tl_a_client_arbiter;
  import tl_arb_pkg::*;

  localparam int OUT_SRC_LSB = 61;
  localparam int DS_W        = 49;
  localparam int DS_SRC_LSB  = 35;

  logic                   clock;
  logic                   reset;
  logic [1:0]             in_a_valid;
  logic [1:0]             in_a_ready;
  logic [2*A_W-1:0]       in_a_bits;
  logic                   out_a_valid;
  logic                   out_a_ready;
  logic [A_W:0]           out_a_bits;
  logic                   out_d_valid;
  logic                   out_d_ready;
  logic [D_W-1:0]         out_d_bits;
  logic [1:0]             in_d_valid;
  logic [1:0]             in_d_ready;
  logic [2*(D_W-1)-1:0]   in_d_bits;
  logic [3:0]             inflight;

  int checks;
  int errors;

  tl_a_client_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .in_a_valid  (in_a_valid),
    .in_a_ready  (in_a_ready),
    .in_a_bits   (in_a_bits),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_a_bits  (out_a_bits),
    .out_d_valid (out_d_valid),
    .out_d_ready (out_d_ready),
    .out_d_bits  (out_d_bits),
    .in_d_valid  (in_d_valid),
    .in_d_ready  (in_d_ready),
    .in_d_bits   (in_d_bits),
    .inflight    (inflight)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] a_valid;
    logic       a_ready;
    logic       d_valid;
    logic [6:0] d_src;
    logic [1:0] d_ready;
    logic       exp_a_valid;
    logic [1:0] exp_a_ready;
    logic [6:0] exp_src;
    logic [1:0] exp_d_valid;
    logic       exp_d_ready;
    logic [3:0] exp_inflight;
  } vec_t;

  vec_t vecs[10];

  typedef struct {
    bit         has;
    logic [2:0] op;
    logic [2:0] size;
    logic [5:0] src;
    int         sent;
    int         total;
  } cmsg_t;

  typedef struct {
    int         client;
    logic [5:0] src;
    logic [2:0] op;
    logic [2:0] size;
    int         beats;
  } resp_t;

  function automatic logic [A_W-1:0] mk_a(input logic [2:0] op, input logic [2:0] size,
                                          input logic [5:0] src, input logic [31:0] data);
    return {op, 3'b000, size, src, 25'h0001000, 4'hF, data};
  endfunction

  function automatic logic [D_W-1:0] mk_d(input logic [2:0] op, input logic [2:0] size,
                                          input logic [6:0] src, input logic [31:0] data);
    return {op, 2'b00, size, src, 3'b000, data};
  endfunction

  // Bytes of the message divided into 4-byte beats, at least one beat.
  function automatic int ref_beats(input int size);
    int b;
    b = (1 << size) / 4;
    return (b < 1) ? 1 : b;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    in_a_valid  = 2'b00;
    in_a_bits   = '0;
    out_a_ready = 1'b0;
    out_d_valid = 1'b0;
    out_d_bits  = '0;
    in_d_ready  = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    in_a_valid  = v.a_valid;
    out_a_ready = v.a_ready;
    in_a_bits   = {mk_a(GET, 3'd2, 6'h11, 32'hAAAA0001), mk_a(GET, 3'd2, 6'h03, 32'h55550000)};
    out_d_valid = v.d_valid;
    out_d_bits  = mk_d(ACK, 3'd2, v.d_src, 32'h0);
    in_d_ready  = v.d_ready;
  endtask

  logic [2:0] rand_ops[4];
  cmsg_t      cm[2];
  resp_t      rq[$];

  initial begin
    int fires;
    int d_sent;
    int m_rr;
    checks = 0;
    errors = 0;
    rand_ops[0] = GET;
    rand_ops[1] = PUT_FULL;
    rand_ops[2] = PUT_PARTIAL;
    rand_ops[3] = ARITH;

    //                a_v  ar   dv   dsrc   dr     eav  ear    esrc   edv    edr  einf
    vecs[0] = '{2'b00, 1'b1, 1'b0, 7'h00, 2'b00, 1'b0, 2'b01, 7'h03, 2'b00, 1'b0, 4'd0};
    vecs[1] = '{2'b11, 1'b1, 1'b0, 7'h00, 2'b00, 1'b1, 2'b01, 7'h03, 2'b00, 1'b0, 4'd0};
    vecs[2] = '{2'b11, 1'b1, 1'b0, 7'h00, 2'b00, 1'b1, 2'b10, 7'h51, 2'b00, 1'b0, 4'd1};
    vecs[3] = '{2'b11, 1'b1, 1'b0, 7'h00, 2'b00, 1'b1, 2'b01, 7'h03, 2'b00, 1'b0, 4'd2};
    vecs[4] = '{2'b01, 1'b1, 1'b0, 7'h00, 2'b00, 1'b1, 2'b01, 7'h03, 2'b00, 1'b0, 4'd3};
    vecs[5] = '{2'b11, 1'b0, 1'b0, 7'h00, 2'b00, 1'b1, 2'b00, 7'h51, 2'b00, 1'b0, 4'd4};
    vecs[6] = '{2'b00, 1'b1, 1'b1, 7'h45, 2'b10, 1'b0, 2'b10, 7'h51, 2'b10, 1'b1, 4'd4};
    vecs[7] = '{2'b10, 1'b1, 1'b1, 7'h02, 2'b10, 1'b1, 2'b10, 7'h51, 2'b01, 1'b0, 4'd3};
    vecs[8] = '{2'b01, 1'b1, 1'b1, 7'h02, 2'b01, 1'b1, 2'b01, 7'h03, 2'b01, 1'b1, 4'd4};
    vecs[9] = '{2'b00, 1'b1, 1'b0, 7'h00, 2'b00, 1'b0, 2'b10, 7'h51, 2'b00, 1'b0, 4'd4};

    // Reset behaviour: outputs held quiet while reset is high, even with traffic offered.
    reset = 1'b1;
    clear_inputs();
    in_a_valid  = 2'b11;
    out_a_ready = 1'b1;
    out_d_valid = 1'b1;
    in_d_ready  = 2'b11;
    @(negedge clock);
    check_output("reset_out_a_valid", 64'(out_a_valid), 64'd0);
    check_output("reset_in_a_ready", 64'(in_a_ready), 64'd0);
    check_output("reset_in_d_valid", 64'(in_d_valid), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    clear_inputs();
    @(negedge clock);
    check_output("reset_inflight", 64'(inflight), 64'd0);
    do_reset();

    // Table-driven single-beat arbitration and D routing.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clock);
      check_output($sformatf("vec%0d_out_a_valid", i), 64'(out_a_valid), 64'(vecs[i].exp_a_valid));
      check_output($sformatf("vec%0d_in_a_ready", i), 64'(in_a_ready), 64'(vecs[i].exp_a_ready));
      check_output($sformatf("vec%0d_out_src", i), 64'(out_a_bits[OUT_SRC_LSB +: 7]), 64'(vecs[i].exp_src));
      check_output($sformatf("vec%0d_in_d_valid", i), 64'(in_d_valid), 64'(vecs[i].exp_d_valid));
      check_output($sformatf("vec%0d_out_d_ready", i), 64'(out_d_ready), 64'(vecs[i].exp_d_ready));
      check_output($sformatf("vec%0d_inflight", i), 64'(inflight), 64'(vecs[i].exp_inflight));
      tick();
    end

    // Four-beat Put from client 0 holds the grant; client 1 follows with no bubble.
    do_reset();
    in_a_bits   = {mk_a(GET, 3'd2, 6'h11, 32'h1), mk_a(PUT_FULL, 3'd4, 6'h03, 32'h2)};
    in_a_valid  = 2'b11;
    out_a_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      check_output($sformatf("burst_beat%0d_ready", b), 64'(in_a_ready), 64'h1);
      check_output($sformatf("burst_beat%0d_src", b), 64'(out_a_bits[OUT_SRC_LSB +: 7]), 64'h03);
      tick();
    end
    @(negedge clock);
    check_output("after_burst_ready", 64'(in_a_ready), 64'h2);
    check_output("after_burst_src", 64'(out_a_bits[OUT_SRC_LSB +: 7]), 64'h51);
    check_output("after_burst_inflight", 64'(inflight), 64'd1);
    tick();
    in_a_valid = 2'b00;

    // Eight outstanding Gets stall the ninth until a D response retires one.
    do_reset();
    in_a_bits   = {mk_a(GET, 3'd2, 6'h11, 32'h0), mk_a(GET, 3'd2, 6'h03, 32'h0)};
    in_a_valid  = 2'b01;
    out_a_ready = 1'b1;
    for (int g = 0; g < 8; g++) begin
      @(negedge clock);
      check_output($sformatf("fill%0d_inflight", g), 64'(inflight), 64'(g));
      tick();
    end
    @(negedge clock);
    check_output("full_out_a_valid", 64'(out_a_valid), 64'd0);
    check_output("full_in_a_ready", 64'(in_a_ready), 64'd0);
    check_output("full_inflight", 64'(inflight), 64'd8);
    out_d_valid = 1'b1;
    out_d_bits  = mk_d(ACK_DATA, 3'd2, 7'h03, 32'hDEAD);
    in_d_ready  = 2'b01;
    @(negedge clock);
    check_output("full_d_ready", 64'(out_d_ready), 64'd1);
    check_output("full_d_valid", 64'(in_d_valid), 64'h1);
    tick();
    out_d_valid = 1'b0;
    in_d_ready  = 2'b00;
    @(negedge clock);
    check_output("release_inflight", 64'(inflight), 64'd7);
    check_output("release_in_a_ready", 64'(in_a_ready), 64'h1);
    check_output("release_out_a_valid", 64'(out_a_valid), 64'd1);
    tick();
    in_a_valid = 2'b00;

    // Four-beat AccessAckData to client 1 with a toggling ready; inflight drops only at the end.
    out_d_valid = 1'b1;
    out_d_bits  = mk_d(ACK_DATA, 3'd4, 7'h45, 32'hBEEF);
    fires = 0;
    for (int j = 0; j < 12 && fires < 4; j++) begin
      in_d_ready = (j % 2 == 0) ? 2'b10 : 2'b00;
      @(negedge clock);
      check_output($sformatf("dburst%0d_valid", j), 64'(in_d_valid), 64'h2);
      check_output($sformatf("dburst%0d_src", j), 64'(in_d_bits[DS_W + DS_SRC_LSB +: 6]), 64'h05);
      check_output($sformatf("dburst%0d_ready", j), 64'(out_d_ready), 64'(in_d_ready[1]));
      check_output($sformatf("dburst%0d_inflight", j), 64'(inflight), 64'd8);
      if (in_d_ready[1]) fires++;
      tick();
    end
    out_d_valid = 1'b0;
    in_d_ready  = 2'b00;
    @(negedge clock);
    check_output("dburst_beats", 64'(fires), 64'd4);
    check_output("dburst_inflight_after", 64'(inflight), 64'd7);
    tick();

    // Reset during beat 2 of a client-1 Put: arbitration restarts from client 0.
    do_reset();
    in_a_bits   = {mk_a(PUT_FULL, 3'd4, 6'h11, 32'h0), mk_a(GET, 3'd2, 6'h03, 32'h0)};
    in_a_valid  = 2'b10;
    out_a_ready = 1'b1;
    @(negedge clock);
    check_output("midreset_first_src", 64'(out_a_bits[OUT_SRC_LSB +: 7]), 64'h51);
    tick();
    in_a_valid = 2'b11;
    reset      = 1'b1;
    @(negedge clock);
    check_output("midreset_out_a_valid", 64'(out_a_valid), 64'd0);
    check_output("midreset_in_a_ready", 64'(in_a_ready), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_output("postreset_inflight", 64'(inflight), 64'd0);
    check_output("postreset_in_a_ready", 64'(in_a_ready), 64'h1);
    check_output("postreset_src", 64'(out_a_bits[OUT_SRC_LSB +: 7]), 64'h03);
    tick();

    // Randomized traffic against a message-level reference model.
    do_reset();
    cm[0] = '{0, 3'd0, 3'd0, 6'd0, 0, 0};
    cm[1] = '{0, 3'd0, 3'd0, 6'd0, 0, 0};
    rq.delete();
    d_sent = 0;
    m_rr   = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int         locked;
      int         sel;
      int         tgt;
      bit         full;
      logic       ev;
      logic [1:0] er;
      logic       a_fire;
      logic       d_fire;
      resp_t      r;
      for (int c = 0; c < 2; c++) begin
        if (!cm[c].has && ($urandom_range(0, 1) == 1)) begin
          cm[c].has   = 1;
          cm[c].op    = rand_ops[$urandom_range(0, 3)];
          cm[c].size  = 3'($urandom_range(0, 4));
          cm[c].src   = 6'($urandom);
          cm[c].sent  = 0;
          cm[c].total = (cm[c].op == PUT_FULL || cm[c].op == PUT_PARTIAL) ? ref_beats(int'(cm[c].size)) : 1;
        end
      end
      in_a_valid  = {cm[1].has, cm[0].has};
      in_a_bits   = {mk_a(cm[1].op, cm[1].size, cm[1].src, $urandom),
                     mk_a(cm[0].op, cm[0].size, cm[0].src, $urandom)};
      out_a_ready = ($urandom_range(0, 3) != 0);
      in_d_ready  = 2'($urandom);
      if (rq.size() > 0 && $urandom_range(0, 2) != 0) begin
        out_d_valid = 1'b1;
        out_d_bits  = mk_d((rq[0].op == GET || rq[0].op == ARITH) ? ACK_DATA : ACK, rq[0].size,
                           {1'(rq[0].client), rq[0].src}, $urandom);
      end else begin
        out_d_valid = 1'b0;
        out_d_bits  = mk_d(ACK, 3'd2, 7'($urandom), $urandom);
      end
      @(negedge clock);

      locked = -1;
      for (int c = 0; c < 2; c++) if (cm[c].has && cm[c].sent > 0) locked = c;
      full = (rq.size() >= MAX_INFLIGHT);
      er   = 2'b00;
      if (locked >= 0) begin
        sel     = locked;
        ev      = 1'b1;
        er[sel] = out_a_ready;
      end else begin
        sel     = cm[m_rr].has ? m_rr : (cm[1 - m_rr].has ? 1 - m_rr : m_rr);
        ev      = cm[sel].has && !full;
        er[sel] = out_a_ready && !full;
      end
      check_output("rand_out_a_valid", 64'(out_a_valid), 64'(ev));
      check_output("rand_in_a_ready", 64'(in_a_ready), 64'(er));
      check_output("rand_inflight", 64'(inflight), 64'(rq.size()));
      if (ev) begin
        check_output("rand_out_src", 64'(out_a_bits[OUT_SRC_LSB +: 7]), 64'({1'(sel), cm[sel].src}));
      end
      tgt = int'(out_d_bits[D_SRC_LSB + 6]);
      check_output("rand_in_d_valid", 64'(in_d_valid), 64'(out_d_valid ? (2'b01 << tgt) : 2'b00));
      check_output("rand_out_d_ready", 64'(out_d_ready), 64'(in_d_ready[tgt]));
      if (out_d_valid) begin
        check_output("rand_d_src", 64'(in_d_bits[tgt*DS_W + DS_SRC_LSB +: 6]), 64'(rq[0].src));
      end

      a_fire = ev && out_a_ready;
      d_fire = out_d_valid && in_d_ready[tgt];
      if (d_fire) begin
        d_sent++;
        if (d_sent == rq[0].beats) begin
          void'(rq.pop_front());
          d_sent = 0;
        end
      end
      if (a_fire) begin
        if (locked < 0) begin
          m_rr     = 1 - sel;
          r.client = sel;
          r.src    = cm[sel].src;
          r.op     = cm[sel].op;
          r.size   = cm[sel].size;
          r.beats  = (cm[sel].op == GET || cm[sel].op == ARITH) ? ref_beats(int'(cm[sel].size)) : 1;
          rq.push_back(r);
        end
        cm[sel].sent++;
        if (cm[sel].sent == cm[sel].total) cm[sel].has = 0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
